// File: rtl/barret_3719_pkg.sv
// Shared constants and stage payload for the mod-3719 Barrett reducer and its arbiter.
package barret_3719_pkg;
   localparam int Q        = 3719;
   localparam int MU       = 4511;
   localparam int K        = 12;
   localparam int IN_W     = 23;
   localparam int OUT_W    = 12;
   localparam int ACC_W    = 24;
   localparam int T_W      = 12;
   localparam int ID_MAX_W = 3;

   typedef struct packed {
      logic [IN_W-1:0]     din;
      logic [T_W-1:0]      t;
      logic [ID_MAX_W-1:0] id;
   } stage_t;
endpackage

// File: rtl/barret_pipe_3719.sv
// Three-stage Barrett reducer (din mod 3719); all stages advance together unless stalled.
module barret_pipe_3719
   import barret_3719_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                in_valid,
   input  logic [IN_W-1:0]     in_din,
   input  logic [ID_MAX_W-1:0] in_id,
   output logic                out_valid,
   output logic [OUT_W-1:0]    out_data,
   output logic [ID_MAX_W-1:0] out_id,
   output logic                busy
);
   logic [3:1]          vld_pipe_q, vld_pipe_d;
   logic [IN_W-1:0]     s1_din_q, s1_din_d;
   logic [ID_MAX_W-1:0] s1_id_q, s1_id_d;
   stage_t              s2_q, s2_d;
   logic [OUT_W-1:0]    data_q, data_d;
   logic [ID_MAX_W-1:0] id_q, id_d;
   logic [ACC_W-1:0]    q_hat, r, r_fold;
   logic                unused_bits;

   always_comb begin
      vld_pipe_d = vld_pipe_q;
      s1_din_d   = s1_din_q;
      s1_id_d    = s1_id_q;
      s2_d       = s2_q;
      data_d     = data_q;
      id_d       = id_q;
      // 24-bit product: (2^23-1)>>12 times MU overflows 23 bits
      q_hat  = ACC_W'(s1_din_q >> K) * ACC_W'(MU);
      r      = ACC_W'(s2_q.din) - ACC_W'(s2_q.t) * ACC_W'(Q);
      r_fold = r;
      if (r_fold >= ACC_W'(Q)) r_fold = r_fold - ACC_W'(Q);
      if (r_fold >= ACC_W'(Q)) r_fold = r_fold - ACC_W'(Q);
      if (!stall) begin
         vld_pipe_d = {vld_pipe_q[2:1], in_valid};
         s1_din_d   = in_din;
         s1_id_d    = in_id;
         s2_d.din   = s1_din_q;
         s2_d.t     = q_hat[ACC_W-1:K];
         s2_d.id    = s1_id_q;
         data_d     = r_fold[OUT_W-1:0];
         id_d       = s2_q.id;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe_q <= '0;
         s1_din_q   <= '0;
         s1_id_q    <= '0;
         s2_q       <= '0;
         data_q     <= '0;
         id_q       <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         s1_din_q   <= s1_din_d;
         s1_id_q    <= s1_id_d;
         s2_q       <= s2_d;
         data_q     <= data_d;
         id_q       <= id_d;
      end
   end

   // Low quotient bits and the zero high bits of the folded remainder are dropped by design
   assign unused_bits = ^{q_hat[K-1:0], r_fold[ACC_W-1:OUT_W]};

   assign out_valid = vld_pipe_q[3];
   assign out_data  = data_q;
   assign out_id    = id_q;
   assign busy      = |vld_pipe_q;
endmodule

// File: rtl/barret_arbiter_3719.sv
// Round-robin arbiter sharing one mod-3719 Barrett pipeline among N_REQ requesters.
module barret_arbiter_3719
   import barret_3719_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req_valid,
   output logic [N_REQ-1:0]            req_ready,
   input  logic [N_REQ-1:0][IN_W-1:0]  req_data,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [OUT_W-1:0]            rsp_data,
   output logic [ID_W-1:0]             rsp_id,
   output logic                        busy
);
   logic [ID_W-1:0]     ptr_q, ptr_d, gnt_idx;
   logic                gnt_found, stall, xfer;
   logic [ID_MAX_W-1:0] pipe_id;
   logic                unused_id;

   always_comb begin
      gnt_idx   = '0;
      gnt_found = 1'b0;
      req_ready = '0;
      // Search begins just past the last winner so each requester gets a turn
      for (int k = 1; k <= N_REQ; k++) begin
         if (!gnt_found && req_valid[ID_W'((int'(ptr_q) + k) % N_REQ)]) begin
            gnt_found = 1'b1;
            gnt_idx   = ID_W'((int'(ptr_q) + k) % N_REQ);
         end
      end
      stall = rsp_valid & ~rsp_ready;
      xfer  = gnt_found & ~stall;
      if (xfer) req_ready[gnt_idx] = 1'b1;
      ptr_d = xfer ? gnt_idx : ptr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= ID_W'(N_REQ - 1);
      else     ptr_q <= ptr_d;
   end

   barret_pipe_3719 u_pipe (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .in_valid  (xfer),
      .in_din    (req_data[gnt_idx]),
      .in_id     (ID_MAX_W'(gnt_idx)),
      .out_valid (rsp_valid),
      .out_data  (rsp_data),
      .out_id    (pipe_id),
      .busy      (busy)
   );

   assign rsp_id    = pipe_id[ID_W-1:0];
   assign unused_id = ^pipe_id;
endmodule

// File: tb/tb_barret_arbiter_3719.sv
// Directed and randomized bench for the shared Barrett reducer arbiter.
module tb_barret_arbiter_3719;
   import barret_3719_pkg::*;
   localparam int N_REQ = 4;
   localparam int ID_W  = 2;
   localparam int NOPS  = 2000;

   logic                       clk = 1'b0;
   logic                       rst;
   logic [N_REQ-1:0]           req_valid;
   logic [N_REQ-1:0]           req_ready;
   logic [N_REQ-1:0][IN_W-1:0] req_data;
   logic                       rsp_valid;
   logic                       rsp_ready;
   logic [OUT_W-1:0]           rsp_data;
   logic [ID_W-1:0]            rsp_id;
   logic                       busy;

   typedef struct { int id; int din; int exp; } vec_t;
   typedef struct { int id; int data; } rsp_t;

   rsp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   n_rsp  = 0;

   barret_arbiter_3719 #(.N_REQ(N_REQ)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      tick();
      rst = 1'b0;
   endtask

   task automatic drain();
      int n;
      for (n = 0; n < 60; n++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0) break;
      end
      chk("drain_done", int'(n < 60), 1);
      chk("drain_empty", exp_q.size(), 0);
      tick();
   endtask

   // Scoreboard: accepted operands queue up with din % Q, responses pop in order
   always @(negedge clk) begin
      if (!rst) begin
         chk("grant_onehot", int'($countones(req_ready) <= 1), 1);
         for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               rsp_t e;
               e.id   = i;
               e.data = int'(req_data[i]) % Q;
               exp_q.push_back(e);
            end
         end
         if (rsp_valid && rsp_ready) begin
            n_rsp++;
            if (exp_q.size() == 0) chk("spurious_rsp", int'(rsp_id), -1);
            else begin
               rsp_t e;
               e = exp_q.pop_front();
               chk("sb_id", int'(rsp_id), e.id);
               chk("sb_data", int'(rsp_data), e.data);
            end
         end
      end
   end

   task automatic run_single(input vec_t v);
      int lat;
      req_data[v.id]  = IN_W'(v.din);
      req_valid[v.id] = 1'b1;
      @(negedge clk);
      chk("single_ready", int'(req_ready), 1 << v.id);
      tick();
      req_valid[v.id] = 1'b0;
      lat = 1;
      while (lat < 10) begin
         @(negedge clk);
         if (rsp_valid) break;
         chk("single_busy", int'(busy), 1);
         tick();
         lat++;
      end
      chk("single_latency", lat, 3);
      chk("single_data", int'(rsp_data), v.exp);
      chk("single_id", int'(rsp_id), v.id);
      chk("single_busy_s3", int'(busy), 1);
      tick();
      @(negedge clk);
      chk("single_idle", int'(busy), 0);
      tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[8];
      int   n0;
      int   sent;
      int   cyc;
      logic [N_REQ-1:0] acc;

      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      rsp_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_rsp_data", int'(rsp_data), 0);
      chk("rst_rsp_id", int'(rsp_id), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_req_ready", int'(req_ready), 0);
      tick();

      vecs[0] = '{1, 1000000, 3308};
      vecs[1] = '{0, 0, 0};
      vecs[2] = '{0, 3718, 3718};
      vecs[3] = '{0, 3719, 0};
      vecs[4] = '{0, 7437, 3718};
      vecs[5] = '{0, 8388607, 2262};
      vecs[6] = '{2, 11157, 0};
      vecs[7] = '{3, 11156, 3718};
      for (int v = 0; v < 8; v++) run_single(vecs[v]);

      // Full contention: grants rotate 0,1,2,3 from reset
      do_reset();
      for (int i = 0; i < N_REQ; i++) req_data[i] = IN_W'(5000 * (i + 1) + 17);
      req_valid = '1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("rr_grant", int'(req_ready), 1 << (k % 4));
         tick();
      end
      req_valid = '0;
      drain();

      // Backpressure: fill the pipe, hold the sink off for 5 cycles
      do_reset();
      n0 = n_rsp;
      req_data[1] = 23'd1000000;
      req_data[2] = 23'd8388607;
      req_data[3] = 23'd7437;
      req_valid   = 4'b1110;
      @(negedge clk); chk("bp_grant_1", int'(req_ready), 4'b0010); tick(); req_valid[1] = 1'b0;
      @(negedge clk); chk("bp_grant_2", int'(req_ready), 4'b0100); tick(); req_valid[2] = 1'b0;
      @(negedge clk); chk("bp_grant_3", int'(req_ready), 4'b1000); tick(); req_valid[3] = 1'b0;
      rsp_ready   = 1'b0;
      req_data[0] = 23'd3719;
      req_data[2] = 23'd4000000;
      req_valid   = 4'b0101;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         chk("bp_hold_valid", int'(rsp_valid), 1);
         chk("bp_hold_data", int'(rsp_data), 3308);
         chk("bp_hold_id", int'(rsp_id), 1);
         chk("bp_no_ready", int'(req_ready), 0);
         chk("bp_busy", int'(busy), 1);
         tick();
      end
      rsp_ready = 1'b1;
      @(negedge clk); chk("bp_ptr_frozen", int'(req_ready), 4'b0001); tick(); req_valid[0] = 1'b0;
      @(negedge clk); chk("bp_grant_2b", int'(req_ready), 4'b0100); tick(); req_valid[2] = 1'b0;
      req_data[3]  = 23'd12345;
      req_valid[3] = 1'b1;
      @(negedge clk); chk("bp_grant_3b", int'(req_ready), 4'b1000); tick(); req_valid[3] = 1'b0;
      drain();
      chk("bp_count", n_rsp - n0, 6);

      // Reset with three entries in flight
      n0 = n_rsp;
      req_data[0]  = 23'd111;
      req_valid[0] = 1'b1;
      tick();
      req_data[0] = 23'd222;
      tick();
      req_data[0] = 23'd333;
      tick();
      req_valid = '0;
      do_reset();
      @(negedge clk);
      chk("flush_rsp_valid", int'(rsp_valid), 0);
      chk("flush_busy", int'(busy), 0);
      tick();
      req_data[2] = 23'd500;
      req_data[0] = 23'd600;
      req_valid   = 4'b0101;
      @(negedge clk); chk("flush_grant_0", int'(req_ready), 4'b0001); tick(); req_valid[0] = 1'b0;
      @(negedge clk); chk("flush_grant_2", int'(req_ready), 4'b0100); tick(); req_valid[2] = 1'b0;
      drain();
      chk("flush_count", n_rsp - n0, 2);

      // Random soak with random sink backpressure
      n0   = n_rsp;
      sent = 0;
      cyc  = 0;
      while ((sent < NOPS || busy || req_valid != '0) && cyc < 20000) begin
         rsp_ready = ($urandom_range(3) != 0);
         for (int i = 0; i < N_REQ; i++) begin
            if (!req_valid[i] && sent < NOPS && $urandom_range(1) == 1) begin
               req_data[i]  = IN_W'($urandom_range(8388607));
               req_valid[i] = 1'b1;
               sent++;
            end
         end
         @(negedge clk);
         acc = req_valid & req_ready;
         tick();
         req_valid = req_valid & ~acc;
         cyc++;
      end
      rsp_ready = 1'b1;
      drain();
      chk("soak_in_time", int'(cyc < 20000), 1);
      chk("soak_count", n_rsp - n0, NOPS);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
